// File: rtl/bcd_scheduler_if.sv
// Link between the scheduler and the shared serial binary-to-BCD convertor.
// The scheduler drives load/data/reset; the convertor returns packed BCD and valid.
interface bcd_scheduler_if;
  logic [7:0] o_conv_data;
  logic       o_conv_load;
  logic       o_conv_rst;
  logic [7:0] i_conv_bcd;
  logic       i_conv_valid;

  modport master (
    output o_conv_data, o_conv_load, o_conv_rst,
    input  i_conv_bcd, i_conv_valid
  );

  modport slave (
    input  o_conv_data, o_conv_load, o_conv_rst,
    output i_conv_bcd, i_conv_valid
  );
endinterface

// File: rtl/bcd_scheduler.sv
// Round-robin scheduler sharing one serial BCD convertor between N display channels.
// Each channel's clamped value is converted in turn and the result held for the 7-segment mux.
module bcd_scheduler #(
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N-1:0]       i_req,
  input  logic [8*N-1:0]     i_value,
  output logic [N-1:0]       o_ack,
  output logic [8*N-1:0]     o_bcd,
  output logic [N-1:0]       o_ovf,
  output logic               o_busy,
  output logic               o_err,
  bcd_scheduler_if.master    conv
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, gnt_q, sel_c, nxt_ptr_c;
  logic           found_c, grant_c, capture_c, timeout_c;
  logic [CW-1:0]  cnt_q;
  logic [7:0]     conv_data_q;
  logic           conv_load_q, conv_rst_q;
  logic [7:0]     sel_value_c, gnt_value_c;
  int             idx;

  function automatic logic [7:0] clamp99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  // Scan upward from ptr, wrapping modulo N, for the first pending request.
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found_c && i_req[idx]) begin
        found_c = 1'b1;
        sel_c   = PW'(idx);
      end
    end
    nxt_ptr_c   = (int'(sel_c) == N - 1) ? '0 : sel_c + PW'(1);
    sel_value_c = i_value[8*sel_c +: 8];
    gnt_value_c = i_value[8*gnt_q +: 8];
  end

  // The first WAIT cycle (cnt_q == 0) is the load cycle, where valid may be stale.
  always_comb begin
    state_d   = state_q;
    grant_c   = 1'b0;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          grant_c = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0 && conv.i_conv_valid) begin
          capture_c = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          timeout_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      conv_data_q <= '0;
      conv_load_q <= 1'b0;
      conv_rst_q  <= 1'b0;
      o_ack       <= '0;
      o_bcd       <= '0;
      o_ovf       <= '0;
      o_err       <= 1'b0;
    end else begin
      conv_load_q <= grant_c;
      conv_rst_q  <= timeout_c;
      o_ack       <= '0;
      if (grant_c) begin
        conv_data_q <= clamp99(sel_value_c);
        gnt_q       <= sel_c;
        ptr_q       <= nxt_ptr_c;
        cnt_q       <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (capture_c) begin
        o_bcd[8*gnt_q +: 8] <= conv.i_conv_bcd;
        o_ovf[gnt_q]        <= (gnt_value_c > 8'd99);
        o_ack[gnt_q]        <= 1'b1;
      end
      if (timeout_c) begin
        o_err        <= 1'b1;
        o_ack[gnt_q] <= 1'b1;
      end
    end
  end

  assign o_busy           = (state_q != IDLE);
  assign conv.o_conv_data = conv_data_q;
  assign conv.o_conv_load = conv_load_q;
  assign conv.o_conv_rst  = ~i_rst_n | conv_rst_q;

endmodule
